mult_add_acc: RTL and testbench

Parametrised, pipelined unsigned multiply-add unit with a valid/ready handshake on both sides and a selectable accumulate mode. Mode 0 produces A*B+C for every accepted sample. Mode 1 sums A*B over a group of ACC_LEN samples, plus the C of the group's first sample, and emits one result per group. It sits between a sample source and a downstream consumer that may apply backpressure, and replaces fixed-width multiply-add stages with a width-generic, flow-controlled version.

---
 rtl/mult_add_acc.sv | 125 ++++++++++++
 tb/tb_mult_add_acc.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mult_add_acc.sv
// Pipelined unsigned multiply-add with valid/ready flow control.
// Mode 0 emits A*B+C per sample; mode 1 emits the sum of A*B over ACC_LEN samples
// plus the C of the first sample in the group.
module mult_add_acc #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ACC_LEN = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic                                       mode,
    input  logic [WIDTH-1:0]                           A,
    input  logic [WIDTH-1:0]                           B,
    input  logic [WIDTH-1:0]                           C,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [2*WIDTH+$clog2(ACC_LEN+1)-1:0]       DATA_OUT
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned OW = 2 * WIDTH + $clog2(ACC_LEN + 1);
    localparam int unsigned CW = $clog2(ACC_LEN);
    localparam logic [CW-1:0] LastCnt = CW'(ACC_LEN - 1);

    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             v1_q, v1_d;
    logic             first1_q, first1_d;
    logic             last1_q, last1_d;
    logic             mode1_q, mode1_d;
    logic [OW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             grp_mode_q, grp_mode_d;
    logic [OW-1:0]    data_q, data_d;
    logic             out_valid_q, out_valid_d;

    logic             en;
    logic             accept;
    logic             mode_eff;
    logic [OW-1:0]    sum;

    assign en        = !out_valid_q || out_ready;
    assign accept    = in_valid && en;
    // mode is only sampled at a group boundary; mid-group the latched mode wins
    assign mode_eff  = (cnt_q == '0) ? mode : grp_mode_q;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign DATA_OUT  = data_q;

    // Next-state for both pipeline stages, group counter and output register
    always_comb begin
        p_d         = p_q;
        c_d         = c_q;
        v1_d        = v1_q;
        first1_d    = first1_q;
        last1_d     = last1_q;
        mode1_d     = mode1_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        grp_mode_d  = grp_mode_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        sum         = '0;

        if (en) begin
            v1_d = accept;
            if (accept) begin
                p_d      = PW'(A) * PW'(B);
                c_d      = C;
                first1_d = (cnt_q == '0);
                mode1_d  = mode_eff;
                last1_d  = !mode_eff || (cnt_q == LastCnt);
                if (mode_eff) begin
                    grp_mode_d = 1'b1;
                    cnt_d      = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
                end else begin
                    grp_mode_d = 1'b0;
                    cnt_d      = '0;
                end
            end

            // en=1 means any held result is being taken (or none is held)
            out_valid_d = 1'b0;
            if (v1_q) begin
                sum   = ((first1_q || !mode1_q) ? OW'(c_q) : acc_q) + OW'(p_q);
                acc_d = sum;
                if (last1_q) begin
                    data_d      = sum;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q         <= '0;
            c_q         <= '0;
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
            last1_q     <= 1'b0;
            mode1_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            grp_mode_q  <= 1'b0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            c_q         <= c_d;
            v1_q        <= v1_d;
            first1_q    <= first1_d;
            last1_q     <= last1_d;
            mode1_q     <= mode1_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            grp_mode_q  <= grp_mode_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mult_add_acc.sv
// Directed self-checking bench for mult_add_acc (WIDTH=8, ACC_LEN=4).
module tb_mult_add_acc;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned ACC_LEN = 4;
    localparam int unsigned OW      = 2 * WIDTH + $clog2(ACC_LEN + 1);

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    data_out;

    int n_tests;
    int n_fail;

    mult_add_acc #(
        .WIDTH   (WIDTH),
        .ACC_LEN (ACC_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .A         (a),
        .B         (b),
        .C         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .DATA_OUT  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input int av, input int bv, input int cv);
        in_valid = v;
        mode     = m;
        a        = WIDTH'(av);
        b        = WIDTH'(bv);
        c        = WIDTH'(cv);
    endtask

    // Four-sample group with an idle cycle option between samples
    task automatic run_group(input string tag, input logic m2, input int gap,
                             input int s_a[4], input int s_b[4], input int s_c[4],
                             input int exp);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0) ? 1'b1 : m2, s_a[i], s_b[i], s_c[i]);
            tick();
            drive(1'b0, 1'b0, 0, 0, 0);
            check_eq({tag, "_noout"}, 32'(out_valid), 32'd0);
            for (int g = 0; g < gap; g++) tick();
        end
        if (gap == 0) tick();
        else check_eq({tag, "_gapvalid"}, 32'(out_valid), 32'd1);
        if (gap == 0) check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(data_out), 32'(exp));
        tick();
        check_eq({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    int sa[3] = '{1, 10, 255};
    int sb[3] = '{2, 10, 255};
    int sc[3] = '{3, 0, 255};
    int se[3] = '{5, 100, 65280};

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 0);
        #12;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        tick();

        // Mode 0 single sample
        drive(1'b1, 1'b0, 3, 4, 5);
        tick();
        drive(1'b0, 1'b0, 0, 0, 0);
        check_eq("m0_lat_novalid", 32'(out_valid), 32'd0);
        tick();
        check_eq("m0_valid", 32'(out_valid), 32'd1);
        check_eq("m0_data", 32'(data_out), 32'd17);
        tick();
        check_eq("m0_clear", 32'(out_valid), 32'd0);

        // Mode 0 streaming back-to-back
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, 1'b0, sa[i], sb[i], sc[i]);
            else drive(1'b0, 1'b0, 0, 0, 0);
            tick();
            if (i > 0) begin
                check_eq("stream_valid", 32'(out_valid), 32'd1);
                check_eq("stream_data", 32'(data_out), 32'(se[i-1]));
            end
        end
        drive(1'b0, 1'b0, 0, 0, 0);
        tick();
        check_eq("stream_end", 32'(out_valid), 32'd0);

        // Mode 1 groups: 6+10, +1, +20, +0 = 37
        run_group("grp", 1'b1, 0, '{2, 1, 4, 0}, '{3, 1, 5, 7}, '{10, 99, 7, 1}, 37);
        run_group("grp_mtog", 1'b0, 0, '{2, 1, 4, 0}, '{3, 1, 5, 7}, '{10, 99, 7, 1}, 37);
        // 4*255*255 + 255, with idle cycles between samples
        run_group("grp_max", 1'b0, 1, '{255, 255, 255, 255}, '{255, 255, 255, 255},
                  '{255, 255, 255, 255}, 260355);

        // Backpressure: results 1, 4, 9 with a 3-cycle stall after the first
        drive(1'b1, 1'b0, 1, 1, 0);
        tick();
        drive(1'b1, 1'b0, 2, 2, 0);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 3, 3, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_inready", 32'(in_ready), 32'd0);
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold", 32'(data_out), 32'd1);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 0, 0, 0);
        check_eq("bp_r2_valid", 32'(out_valid), 32'd1);
        check_eq("bp_r2", 32'(data_out), 32'd4);
        tick();
        check_eq("bp_r3_valid", 32'(out_valid), 32'd1);
        check_eq("bp_r3", 32'(data_out), 32'd9);
        tick();
        check_eq("bp_end", 32'(out_valid), 32'd0);

        // Mid-group reset with a nonzero held result
        drive(1'b1, 1'b1, 5, 5, 5);
        tick();
        drive(1'b1, 1'b1, 5, 5, 0);
        tick();
        drive(1'b0, 1'b0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check_eq("mrst_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_data", 32'(data_out), 32'd0);
        check_eq("mrst_ready", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        // A fresh group of four 1*1 samples must give 4 if the partial group was dropped
        run_group("post_rst", 1'b1, 0, '{1, 1, 1, 1}, '{1, 1, 1, 1}, '{0, 0, 0, 0}, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
